// File: rtl/bcd_counter_nd_pkg.sv
// Shared BCD constants and the per-digit clamp helper for the N-digit counter.
package bcd_counter_nd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_DIGIT_MAX = 4'd9;

  // min(nibble, min(max, 9)): clamps a digit to its effective rollover maximum
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble,
                                                 input logic [BCD_W-1:0] max);
    logic [BCD_W-1:0] lim_s;
    lim_s = (max > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : max;
    return (nibble > lim_s) ? lim_s : nibble;
  endfunction

endpackage

// File: rtl/bcd_counter_nd_digit.sv
// One BCD digit register: set has priority over increment, increment over decrement.
module bcd_digit
  import bcd_counter_nd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_set,
  input  logic [BCD_W-1:0] i_set_val,
  input  logic [BCD_W-1:0] i_max,
  output logic [BCD_W-1:0] o_val,
  output logic             o_at_max,
  output logic             o_at_zero
);

  logic [BCD_W-1:0] max_eff_s;
  logic [BCD_W-1:0] val_nxt_s;
  logic [BCD_W-1:0] val_r;

  assign max_eff_s = bcd_clamp(i_max, BCD_DIGIT_MAX);
  // A value above the effective max (max lowered at runtime) counts as at max
  assign o_at_max  = (val_r >= max_eff_s);
  assign o_at_zero = (val_r == 4'd0);
  assign o_val     = val_r;

  // Next-value selection for this digit
  always_comb begin
    val_nxt_s = val_r;
    if (i_set) begin
      val_nxt_s = i_set_val;
    end else if (i_inc) begin
      val_nxt_s = o_at_max ? 4'd0 : (val_r + 4'd1);
    end else if (i_dec) begin
      val_nxt_s = o_at_zero ? max_eff_s : (val_r - 4'd1);
    end else begin
      val_nxt_s = val_r;
    end
  end

  // Digit state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_r <= 4'd0;
    end else begin
      val_r <= val_nxt_s;
    end
  end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit packed-BCD up/down counter with per-digit maxima and a whole-value wrap limit.
module bcd_counter_nd
  import bcd_counter_nd_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_load,
  input  logic [BCD_W*DIGITS-1:0] i_load_val,
  input  logic                    i_en,
  input  logic                    i_dir,
  input  logic [BCD_W*DIGITS-1:0] i_max,
  input  logic [BCD_W*DIGITS-1:0] i_limit,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic                    o_carry,
  output logic                    o_borrow
);

  localparam int W = BCD_W * DIGITS;

  logic [DIGITS-1:0] at_max_s;
  logic [DIGITS-1:0] at_zero_s;
  logic [DIGITS-1:0] inc_s;
  logic [DIGITS-1:0] dec_s;
  logic [W-1:0]      load_clamp_s;
  logic [W-1:0]      load_val_s;
  logic [W-1:0]      set_val_s;
  logic              set_s;
  logic              up_wrap_s;
  logic              down_wrap_s;
  logic              step_up_s;
  logic              step_dn_s;

  // Terminal-count detection; packed compares are valid while digits stay <= 9
  always_comb begin
    up_wrap_s   = i_en & ~i_dir & (o_bcd >= i_limit);
    down_wrap_s = i_en & i_dir & (o_bcd == {W{1'b0}});
  end

  assign o_carry  = up_wrap_s & ~i_rst;
  assign o_borrow = down_wrap_s & ~i_rst;

  // Load value: clamp each digit to its max, then clamp the whole value to the limit
  always_comb begin
    load_clamp_s = {W{1'b0}};
    for (int d = 0; d < DIGITS; d++) begin
      load_clamp_s[d*BCD_W +: BCD_W] = bcd_clamp(i_load_val[d*BCD_W +: BCD_W],
                                                 i_max[d*BCD_W +: BCD_W]);
    end
    load_val_s = (load_clamp_s > i_limit) ? i_limit : load_clamp_s;
  end

  // Whole-value set source: clear > load > up wrap > down wrap
  always_comb begin
    set_s     = 1'b0;
    set_val_s = {W{1'b0}};
    if (i_clr) begin
      set_s     = 1'b1;
      set_val_s = {W{1'b0}};
    end else if (i_load) begin
      set_s     = 1'b1;
      set_val_s = load_val_s;
    end else if (up_wrap_s) begin
      set_s     = 1'b1;
      set_val_s = {W{1'b0}};
    end else if (down_wrap_s) begin
      set_s     = 1'b1;
      set_val_s = i_limit;
    end else begin
      set_s     = 1'b0;
      set_val_s = {W{1'b0}};
    end
  end

  assign step_up_s = i_en & ~i_dir & ~set_s;
  assign step_dn_s = i_en & i_dir & ~set_s;

  // Ripple-enable chain: a digit steps when every lower digit is at max (up) or zero (down)
  always_comb begin
    logic up_run_s;
    logic dn_run_s;
    up_run_s = step_up_s;
    dn_run_s = step_dn_s;
    inc_s    = {DIGITS{1'b0}};
    dec_s    = {DIGITS{1'b0}};
    for (int d = 0; d < DIGITS; d++) begin
      inc_s[d] = up_run_s;
      dec_s[d] = dn_run_s;
      up_run_s = up_run_s & at_max_s[d];
      dn_run_s = dn_run_s & at_zero_s[d];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_inc     (inc_s[g]),
      .i_dec     (dec_s[g]),
      .i_set     (set_s),
      .i_set_val (set_val_s[g*BCD_W +: BCD_W]),
      .i_max     (i_max[g*BCD_W +: BCD_W]),
      .o_val     (o_bcd[g*BCD_W +: BCD_W]),
      .o_at_max  (at_max_s[g]),
      .o_at_zero (at_zero_s[g])
    );
  end

endmodule
